// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//
// Owns the 5-entry output-enable / PWM configuration register bank and
// arbitrates single-register write requests from two requesters:
//   port A : SPI peripheral decode
//   port B : on-chip sequencer / test engine
//
// Each transaction takes three cycles: IDLE (pick winner), GRANT (one-cycle
// ready pulse to the winner, capture its address/data) and WRITE (commit).
// When both ports request together, the port that was not granted last wins.
//
// Optional build macro:
//   SHADOW_UPDATE_EN  - writes land in a shadow bank; the visible outputs copy
//                       the whole shadow bank on the cycle after period_start.
//                       Undefined: writes update the outputs directly and
//                       period_start is ignored.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_valid/a_addr/a_data, a_ready   port A write request and accept pulse
//   b_valid/b_addr/b_data, b_ready   port B write request and accept pulse
//   period_start                     PWM period boundary pulse (shadow mode)
//   err_clr                          clears err_addr
//   err_addr                         sticky out-of-range address flag
//   last_grant                       0 = A granted last, 1 = B granted last
//   en_reg_out_7_0 .. pwm_duty_cycle register 0 .. register 4
// ---------------------------------------------------------------------------
module reg_bank_arbiter #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              period_start,
    input  logic              err_clr,
    output logic              err_addr,
    output logic              last_grant,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;

    // winner encoding matches last_grant: 0 = port A, 1 = port B
    logic                winner_q;
    logic                winner_d;
    logic                a_ready_q;
    logic                a_ready_d;
    logic                b_ready_q;
    logic                b_ready_d;
    logic                capture_s;
    logic                commit_s;

    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                addr_ok_s;
    logic                last_grant_q;
    logic                err_q;
    logic [DATA_W-1:0]   out_q [NUM_REGS];

    // State register and registered ready pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            winner_q  <= 1'b0;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
        end
    end

    // Next-state, arbitration and datapath strobes
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        a_ready_d = 1'b0;
        b_ready_d = 1'b0;
        capture_s = 1'b0;
        commit_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_valid || b_valid) begin
                    // With both requesting, the port not granted last wins.
                    if (a_valid && b_valid) begin
                        winner_d = ~last_grant_q;
                    end else begin
                        winner_d = b_valid;
                    end
                    a_ready_d = ~winner_d;
                    b_ready_d = winner_d;
                    state_d   = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                capture_s = 1'b1;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                commit_s = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request while its ready pulse is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
        end else if (capture_s) begin
            wr_addr_q <= winner_q ? b_addr : a_addr;
            wr_data_q <= winner_q ? b_data : a_data;
        end else begin
            wr_addr_q <= wr_addr_q;
            wr_data_q <= wr_data_q;
        end
    end

    // Full-width compare: upper address bits never alias onto real registers
    assign addr_ok_s = (wr_addr_q < ADDR_W'(NUM_REGS));

    // Record which port completed the most recent transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (commit_s) begin
            last_grant_q <= winner_q;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

    // Sticky address error; a new error beats a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (commit_s && !addr_ok_s) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q;
        end
    end

`ifdef SHADOW_UPDATE_EN
    logic [DATA_W-1:0] shadow_q [NUM_REGS];

    // Shadow bank takes committed writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && addr_ok_s && (wr_addr_q == ADDR_W'(i))) begin
                    shadow_q[i] <= wr_data_q;
                end else begin
                    shadow_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // Outputs load the pre-edge shadow contents, so a write committed on the
    // same edge as period_start waits for the following period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                out_q[i] <= {DATA_W{1'b0}};
            end
        end else if (period_start) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                out_q[i] <= shadow_q[i];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                out_q[i] <= out_q[i];
            end
        end
    end
`else
    logic period_start_unused_s;
    assign period_start_unused_s = period_start;

    // Committed writes go straight to the visible register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                out_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_s && addr_ok_s && (wr_addr_q == ADDR_W'(i))) begin
                    out_q[i] <= wr_data_q;
                end else begin
                    out_q[i] <= out_q[i];
                end
            end
        end
    end
`endif

    assign a_ready         = a_ready_q;
    assign b_ready         = b_ready_q;
    assign err_addr        = err_q;
    assign last_grant      = last_grant_q;
    assign en_reg_out_7_0  = out_q[0];
    assign en_reg_out_15_8 = out_q[1];
    assign en_reg_pwm_7_0  = out_q[2];
    assign en_reg_pwm_15_8 = out_q[3];
    assign pwm_duty_cycle  = out_q[4];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//
// Randomized bench for reg_bank_arbiter. Two requesters raise random writes
// (addresses 0..7, so out-of-range addresses occur) and hold them until their
// accept pulse. A transaction-timeline model predicts when each port is
// accepted, when registers change, err_addr and last_grant. Ends with a
// reset asserted while a grant is in flight.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              period_start;
    logic              err_clr;
    logic              err_addr;
    logic              last_grant;
    logic [DATA_W-1:0] en_reg_out_7_0;
    logic [DATA_W-1:0] en_reg_out_15_8;
    logic [DATA_W-1:0] en_reg_pwm_7_0;
    logic [DATA_W-1:0] en_reg_pwm_15_8;
    logic [DATA_W-1:0] pwm_duty_cycle;

    always #5 clk = ~clk;

    reg_bank_arbiter #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_valid        (a_valid),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .period_start   (period_start),
        .err_clr        (err_clr),
        .err_addr       (err_addr),
        .last_grant     (last_grant),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DATA_W-1:0] m_out    [NUM_REGS];
    logic [DATA_W-1:0] m_shadow [NUM_REGS];
    logic              m_err;
    logic              m_last;
    int                cyc;
    int                free_cyc;
    int                commit_cyc;
    int                rdy_cyc_a;
    int                rdy_cyc_b;
    logic              c_port;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    // Requester state
    logic              pa, pb;
    logic [ADDR_W-1:0] aa, ab;
    logic [DATA_W-1:0] da, db;
    bit                gen_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_out[i]    = '0;
            m_shadow[i] = '0;
        end
        m_err      = 1'b0;
        m_last     = 1'b1;
        cyc        = 0;
        free_cyc   = 0;
        commit_cyc = -10;
        rdy_cyc_a  = -10;
        rdy_cyc_b  = -10;
    endtask

    task automatic check_all();
        logic [DATA_W-1:0] dut_regs [NUM_REGS];
        dut_regs[0] = en_reg_out_7_0;
        dut_regs[1] = en_reg_out_15_8;
        dut_regs[2] = en_reg_pwm_7_0;
        dut_regs[3] = en_reg_pwm_15_8;
        dut_regs[4] = pwm_duty_cycle;
        check_val("a_ready", 32'(a_ready), 32'(rdy_cyc_a == cyc));
        check_val("b_ready", 32'(b_ready), 32'(rdy_cyc_b == cyc));
        check_val("err_addr", 32'(err_addr), 32'(m_err));
        check_val("last_grant", 32'(last_grant), 32'(m_last));
        for (int i = 0; i < NUM_REGS; i++) begin
            check_val($sformatf("reg%0d", i), 32'(dut_regs[i]), 32'(m_out[i]));
        end
    endtask

    // One clock cycle: update requesters, drive inputs, predict the edge, compare.
    task automatic step(input logic ps, input logic ec);
        logic set_err;
        if (pa && rdy_cyc_a == cyc - 1) pa = 1'b0;
        if (pb && rdy_cyc_b == cyc - 1) pb = 1'b0;
        if (gen_en) begin
            if (!pa && $urandom_range(0, 2) == 0) begin
                pa = 1'b1;
                aa = 4'($urandom_range(0, 7));
                da = 8'($urandom);
            end
            if (!pb && $urandom_range(0, 2) == 0) begin
                pb = 1'b1;
                ab = 4'($urandom_range(0, 7));
                db = 8'($urandom);
            end
        end
        a_valid      = pa;
        a_addr       = aa;
        a_data       = da;
        b_valid      = pb;
        b_addr       = ab;
        b_data       = db;
        period_start = ps;
        err_clr      = ec;

        // Effects of the edge that ends this cycle
        set_err = 1'b0;
`ifdef SHADOW_UPDATE_EN
        if (ps) begin
            for (int i = 0; i < NUM_REGS; i++) m_out[i] = m_shadow[i];
        end
`endif
        if (cyc == commit_cyc) begin
            if (int'(c_addr) < NUM_REGS) begin
`ifdef SHADOW_UPDATE_EN
                m_shadow[int'(c_addr)] = c_data;
`else
                m_out[int'(c_addr)] = c_data;
`endif
            end else begin
                set_err = 1'b1;
            end
            m_last = c_port;
        end
        if (set_err) m_err = 1'b1;
        else if (ec) m_err = 1'b0;

        if (cyc >= free_cyc && (pa || pb)) begin
            c_port = (pa && pb) ? ~m_last : pb;
            c_addr = c_port ? ab : aa;
            c_data = c_port ? db : da;
            if (c_port) rdy_cyc_b = cyc + 1;
            else        rdy_cyc_a = cyc + 1;
            commit_cyc = cyc + 2;
            free_cyc   = cyc + 3;
        end

        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        rst_n        = 1'b0;
        a_valid      = 1'b0;
        a_addr       = '0;
        a_data       = '0;
        b_valid      = 1'b0;
        b_addr       = '0;
        b_data       = '0;
        period_start = 1'b0;
        err_clr      = 1'b0;
        pa = 1'b0; pb = 1'b0;
        aa = '0; ab = '0; da = '0; db = '0;
        gen_en = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Drain outstanding requests, then reset while a grant is in flight.
        gen_en = 1'b0;
        for (int n = 0; n < 12; n++) step(1'b1, 1'b0);
        pa = 1'b1; aa = 4'd2; da = 8'hFF;
        pb = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("rst_a_ready", 32'(a_ready), 32'd0);
        check_val("rst_b_ready", 32'(b_ready), 32'd0);
        check_val("rst_pwm_7_0", 32'(en_reg_pwm_7_0), 32'd0);
        check_val("rst_last_grant", 32'(last_grant), 32'd1);
        check_val("rst_err_addr", 32'(err_addr), 32'd0);
        model_reset();
        pa = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
